// File: rtl/link_writeback_pipe_if.sv
// link_writeback_pipe_if
// Groups every non-clock signal of the writeback/link pipe into one bundle.
//   Input side : valid_in, stall, flush, instruction, pc_in,
//                reg_write_addr_in, reg_write_en_in, alu_result
//   Output side: valid_out, reg_write_en_out, reg_write_addr_out,
//                reg_write_data_out, is_link_out
// Modports:
//   master - the stage upstream of the pipe; drives the inputs and
//            observes the register-file write port.
//   slave  - the pipe itself.
interface link_writeback_pipe_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  valid_in;
    logic                  stall;
    logic                  flush;
    logic [31:0]           instruction;
    logic [DATA_WIDTH-1:0] pc_in;
    logic [4:0]            reg_write_addr_in;
    logic                  reg_write_en_in;
    logic [DATA_WIDTH-1:0] alu_result;

    logic                  valid_out;
    logic                  reg_write_en_out;
    logic [4:0]            reg_write_addr_out;
    logic [DATA_WIDTH-1:0] reg_write_data_out;
    logic                  is_link_out;

    modport master (
        output valid_in, stall, flush, instruction, pc_in,
               reg_write_addr_in, reg_write_en_in, alu_result,
        input  valid_out, reg_write_en_out, reg_write_addr_out,
               reg_write_data_out, is_link_out
    );

    modport slave (
        input  valid_in, stall, flush, instruction, pc_in,
               reg_write_addr_in, reg_write_en_in, alu_result,
        output valid_out, reg_write_en_out, reg_write_addr_out,
               reg_write_data_out, is_link_out
    );
endinterface

// File: rtl/link_writeback_pipe.sv
// link_writeback_pipe
// Classifies the instruction at the decode/execute boundary as linking
// (JAL, BLTZAL, BGEZAL, JALR) or non-linking, picks the destination
// register and writeback data (link address or ALU result), and carries
// the entry through STAGES register stages to the register-file write port.
// Writes to $0 are suppressed.
//
// Parameters:
//   DATA_WIDTH  - width of PC, ALU result and writeback data
//   STAGES      - number of register stages, 1..8
//   LINK_REG    - destination for JAL / BLTZAL / BGEZAL
//   LINK_OFFSET - byte offset from pc_in to the link address
// Ports:
//   clk     - rising-edge clock
//   reset_n - asynchronous active-low reset, clears every stage
//   bus     - slave side of link_writeback_pipe_if (inputs, stall/flush
//             control and the register-file write port)
module link_writeback_pipe #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned STAGES      = 2,
    parameter int unsigned LINK_REG    = 31,
    parameter int unsigned LINK_OFFSET = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    link_writeback_pipe_if.slave  bus
);

    // Decode patterns as mask/match pairs over the whole instruction word.
    // JAL:           opcode 000011
    // BLTZAL/BGEZAL: opcode 000001, rt 1000x (rt[0] selects the condition,
    //                which does not matter because links happen regardless)
    // JALR:          opcode 000000, funct 001001
    localparam logic [31:0] JAL_MASK   = 32'hFC00_0000;
    localparam logic [31:0] JAL_MATCH  = 32'h0C00_0000;
    localparam logic [31:0] BAL_MASK   = 32'hFC1E_0000;
    localparam logic [31:0] BAL_MATCH  = 32'h0410_0000;
    localparam logic [31:0] JALR_MASK  = 32'hFC00_003F;
    localparam logic [31:0] JALR_MATCH = 32'h0000_0009;

    localparam logic [4:0]            LINK_ADDR = 5'(LINK_REG);
    localparam logic [DATA_WIDTH-1:0] LINK_ADD  = DATA_WIDTH'(LINK_OFFSET);

    typedef struct packed {
        logic                  valid;
        logic                  wen;
        logic [4:0]            addr;
        logic [DATA_WIDTH-1:0] data;
        logic                  is_link;
    } entry_t;

    localparam entry_t BUBBLE = '0;

    // Build the stage-1 entry for one input slot. An invalid slot becomes
    // an all-zero bubble so nothing downstream can ever write from it.
    function automatic entry_t classify(
        input logic                  valid,
        input logic [31:0]           instr,
        input logic [DATA_WIDTH-1:0] pc,
        input logic [4:0]            addr_in,
        input logic                  wen_in,
        input logic [DATA_WIDTH-1:0] alu
    );
        entry_t e;
        logic   fixed_link;
        logic   reg_link;

        fixed_link = ((instr & JAL_MASK) == JAL_MATCH) ||
                     ((instr & BAL_MASK) == BAL_MATCH);
        reg_link   = ((instr & JALR_MASK) == JALR_MATCH);

        e = BUBBLE;
        if (!valid) begin
            e = BUBBLE;
        end else if (fixed_link) begin
            e.valid   = 1'b1;
            e.wen     = 1'b1;
            e.addr    = LINK_ADDR;
            e.data    = pc + LINK_ADD;
            e.is_link = 1'b1;
        end else if (reg_link) begin
            // JALR links into its rd field, which the decoder already
            // presents as the destination address.
            e.valid   = 1'b1;
            e.wen     = 1'b1;
            e.addr    = addr_in;
            e.data    = pc + LINK_ADD;
            e.is_link = 1'b1;
        end else begin
            e.valid   = 1'b1;
            e.wen     = wen_in;
            e.addr    = addr_in;
            e.data    = alu;
            e.is_link = 1'b0;
        end

        // $0 is hard-wired; a write there is dropped but the link flag stays.
        if (e.addr == 5'd0) begin
            e.wen = 1'b0;
        end else begin
            e.wen = e.wen;
        end

        return e;
    endfunction

    entry_t in_entry_s;
    entry_t stage_r [STAGES];

    // Classify the current input slot.
    always_comb begin
        in_entry_s = classify(bus.valid_in, bus.instruction, bus.pc_in,
                              bus.reg_write_addr_in, bus.reg_write_en_in,
                              bus.alu_result);
    end

    // Stage registers: flush beats stall, stall freezes everything,
    // otherwise every stage shifts by one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_r[k] <= BUBBLE;
            end
        end else if (bus.flush) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_r[k] <= BUBBLE;
            end
        end else if (!bus.stall) begin
            stage_r[0] <= in_entry_s;
            for (int k = 1; k < STAGES; k++) begin
                stage_r[k] <= stage_r[k-1];
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                stage_r[k] <= stage_r[k];
            end
        end
    end

    // Outputs come straight from the last stage register. The valid gate
    // on the write enable keeps a bubble from ever writing even if a
    // stage bit were to disagree.
    assign bus.valid_out          = stage_r[STAGES-1].valid;
    assign bus.reg_write_en_out   = stage_r[STAGES-1].wen & stage_r[STAGES-1].valid;
    assign bus.reg_write_addr_out = stage_r[STAGES-1].addr;
    assign bus.reg_write_data_out = stage_r[STAGES-1].data;
    assign bus.is_link_out        = stage_r[STAGES-1].is_link;

endmodule

// File: tb/tb_link_writeback_pipe.sv
// tb_link_writeback_pipe
// Directed bench for link_writeback_pipe with default parameters
// (DATA_WIDTH 32, STAGES 2, LINK_REG 31, LINK_OFFSET 8). Expected values
// are hand-computed and packed as {valid, wen, addr, data, is_link}.
module tb_link_writeback_pipe;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;

    link_writeback_pipe_if #(.DATA_WIDTH(32)) bus ();

    link_writeback_pipe #(
        .DATA_WIDTH (32),
        .STAGES     (2),
        .LINK_REG   (31),
        .LINK_OFFSET(8)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [39:0] pack(input logic v, input logic e,
                                         input logic [4:0] a,
                                         input logic [31:0] d,
                                         input logic l);
        return {v, e, a, d, l};
    endfunction

    function automatic logic [39:0] obs();
        return {bus.valid_out, bus.reg_write_en_out, bus.reg_write_addr_out,
                bus.reg_write_data_out, bus.is_link_out};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr,
                         input logic [31:0] pc, input logic [4:0] addr,
                         input logic en, input logic [31:0] alu);
        bus.valid_in          = v;
        bus.instruction       = instr;
        bus.pc_in             = pc;
        bus.reg_write_addr_in = addr;
        bus.reg_write_en_in   = en;
        bus.alu_result        = alu;
    endtask

    task automatic bubble();
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        drive(1'b1, 32'h0C00_0010, 32'h0040_0000, 5'd3, 1'b1, 32'h1);
        #3;
        checks++;
        if (obs() !== 40'h0) begin
            failures++;
            $display("FAIL reset_state got=%h exp=%h", obs(), 40'h0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        bubble();
        tick();
    endtask

    task automatic test_jal();
        logic [39:0] exp;
        drive(1'b1, 32'h0C00_0010, 32'h0040_0000, 5'd7, 1'b0, 32'h1234);
        tick();
        checks++;
        if (obs() !== 40'h0) begin
            failures++;
            $display("FAIL jal_early got=%h exp=%h", obs(), 40'h0);
        end
        bubble();
        tick();
        exp = pack(1'b1, 1'b1, 5'd31, 32'h0040_0008, 1'b1);
        checks++;
        if (obs() !== exp) begin
            failures++;
            $display("FAIL jal got=%h exp=%h", obs(), exp);
        end
    endtask

    // Back-to-back linking / near-miss instructions, one per cycle.
    task automatic test_link_forms();
        logic [31:0] ins [6];
        logic [31:0] pcs [6];
        logic [4:0]  adr [6];
        logic        ens [6];
        logic [31:0] alu [6];
        logic [39:0] exp [6];
        ins[0] = 32'h0411_0010; pcs[0] = 32'h2000; adr[0] = 5'd3;  ens[0] = 1'b0; alu[0] = 32'h0;
        exp[0] = pack(1'b1, 1'b1, 5'd31, 32'h2008, 1'b1);          // BGEZAL
        ins[1] = 32'h0410_0004; pcs[1] = 32'h3000; adr[1] = 5'd0;  ens[1] = 1'b0; alu[1] = 32'h0;
        exp[1] = pack(1'b1, 1'b1, 5'd31, 32'h3008, 1'b1);          // BLTZAL
        ins[2] = 32'h0080_2809; pcs[2] = 32'h0100; adr[2] = 5'd5;  ens[2] = 1'b1; alu[2] = 32'h99;
        exp[2] = pack(1'b1, 1'b1, 5'd5, 32'h0108, 1'b1);           // JALR rd=5
        ins[3] = 32'h0080_0009; pcs[3] = 32'h0200; adr[3] = 5'd0;  ens[3] = 1'b1; alu[3] = 32'h98;
        exp[3] = pack(1'b1, 1'b0, 5'd0, 32'h0208, 1'b1);           // JALR rd=0
        ins[4] = 32'h0412_0000; pcs[4] = 32'h0300; adr[4] = 5'd12; ens[4] = 1'b1; alu[4] = 32'h55;
        exp[4] = pack(1'b1, 1'b1, 5'd12, 32'h55, 1'b0);            // regimm rt=10010
        ins[5] = 32'h0080_0008; pcs[5] = 32'h0400; adr[5] = 5'd6;  ens[5] = 1'b1; alu[5] = 32'h77;
        exp[5] = pack(1'b1, 1'b1, 5'd6, 32'h77, 1'b0);             // JR
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, ins[i], pcs[i], adr[i], ens[i], alu[i]);
            tick();
            if (i > 0) begin
                checks++;
                if (obs() !== exp[i-1]) begin
                    failures++;
                    $display("FAIL link_form_%0d got=%h exp=%h", i-1, obs(), exp[i-1]);
                end
            end
        end
        bubble();
        tick();
        checks++;
        if (obs() !== exp[5]) begin
            failures++;
            $display("FAIL link_form_5 got=%h exp=%h", obs(), exp[5]);
        end
    endtask

    task automatic test_nonlink_and_wrap();
        logic        vld [5];
        logic [31:0] ins [5];
        logic [31:0] pcs [5];
        logic [4:0]  adr [5];
        logic        ens [5];
        logic [31:0] alu [5];
        logic [39:0] exp [5];
        vld[0] = 1'b1; ins[0] = 32'h0022_4821; pcs[0] = 32'h10; adr[0] = 5'd9; ens[0] = 1'b1; alu[0] = 32'hDEAD_BEEF;
        exp[0] = pack(1'b1, 1'b1, 5'd9, 32'hDEAD_BEEF, 1'b0);      // ADDU
        vld[1] = 1'b1; ins[1] = 32'h0022_0021; pcs[1] = 32'h14; adr[1] = 5'd0; ens[1] = 1'b1; alu[1] = 32'h11;
        exp[1] = pack(1'b1, 1'b0, 5'd0, 32'h11, 1'b0);             // write to $0
        vld[2] = 1'b1; ins[2] = 32'hAC22_0000; pcs[2] = 32'h18; adr[2] = 5'd4; ens[2] = 1'b0; alu[2] = 32'h22;
        exp[2] = pack(1'b1, 1'b0, 5'd4, 32'h22, 1'b0);             // no write
        vld[3] = 1'b1; ins[3] = 32'h0C00_0001; pcs[3] = 32'hFFFF_FFFC; adr[3] = 5'd2; ens[3] = 1'b0; alu[3] = 32'h0;
        exp[3] = pack(1'b1, 1'b1, 5'd31, 32'h0000_0004, 1'b1);     // JAL wrap
        vld[4] = 1'b0; ins[4] = 32'h0C00_0001; pcs[4] = 32'h500; adr[4] = 5'd8; ens[4] = 1'b1; alu[4] = 32'h33;
        exp[4] = 40'h0;                                             // invalid slot
        for (int i = 0; i < 5; i++) begin
            drive(vld[i], ins[i], pcs[i], adr[i], ens[i], alu[i]);
            tick();
            if (i > 0) begin
                checks++;
                if (obs() !== exp[i-1]) begin
                    failures++;
                    $display("FAIL nonlink_%0d got=%h exp=%h", i-1, obs(), exp[i-1]);
                end
            end
        end
        bubble();
        tick();
        checks++;
        if (obs() !== exp[4]) begin
            failures++;
            $display("FAIL nonlink_4 got=%h exp=%h", obs(), exp[4]);
        end
    endtask

    task automatic test_stall();
        logic [39:0] ea;
        logic [39:0] eb;
        logic [39:0] ec;
        ea = pack(1'b1, 1'b1, 5'd10, 32'hA0, 1'b0);
        eb = pack(1'b1, 1'b1, 5'd11, 32'hB0, 1'b0);
        ec = pack(1'b1, 1'b1, 5'd12, 32'hC0, 1'b0);
        drive(1'b1, 32'h0, 32'h0, 5'd10, 1'b1, 32'hA0);
        tick();
        drive(1'b1, 32'h0, 32'h0, 5'd11, 1'b1, 32'hB0);
        tick();
        checks++;
        if (obs() !== ea) begin
            failures++;
            $display("FAIL stall_a got=%h exp=%h", obs(), ea);
        end
        drive(1'b1, 32'h0, 32'h0, 5'd12, 1'b1, 32'hC0);
        tick();
        checks++;
        if (obs() !== eb) begin
            failures++;
            $display("FAIL stall_b got=%h exp=%h", obs(), eb);
        end
        bus.stall = 1'b1;
        drive(1'b1, 32'h0C00_0000, 32'h40, 5'd13, 1'b1, 32'hD0);
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (obs() !== eb) begin
                failures++;
                $display("FAIL stall_hold_%0d got=%h exp=%h", c, obs(), eb);
            end
        end
        bus.stall = 1'b0;
        bubble();
        tick();
        checks++;
        if (obs() !== ec) begin
            failures++;
            $display("FAIL stall_c got=%h exp=%h", obs(), ec);
        end
        tick();
        checks++;
        if (obs() !== 40'h0) begin
            failures++;
            $display("FAIL stall_drain got=%h exp=%h", obs(), 40'h0);
        end
    endtask

    task automatic test_flush();
        logic [39:0] ea;
        ea = pack(1'b1, 1'b1, 5'd20, 32'h1111, 1'b0);
        drive(1'b1, 32'h0, 32'h0, 5'd20, 1'b1, 32'h1111);
        tick();
        drive(1'b1, 32'h0, 32'h0, 5'd21, 1'b1, 32'h2222);
        tick();
        checks++;
        if (obs() !== ea) begin
            failures++;
            $display("FAIL flush_pre got=%h exp=%h", obs(), ea);
        end
        bus.flush = 1'b1;
        bus.stall = 1'b1;
        drive(1'b1, 32'h0C00_0000, 32'h80, 5'd22, 1'b1, 32'h3333);
        tick();
        checks++;
        if (obs() !== 40'h0) begin
            failures++;
            $display("FAIL flush_stall got=%h exp=%h", obs(), 40'h0);
        end
        bus.flush = 1'b0;
        bus.stall = 1'b0;
        bubble();
        tick();
        checks++;
        if (obs() !== 40'h0) begin
            failures++;
            $display("FAIL flush_killed got=%h exp=%h", obs(), 40'h0);
        end
    endtask

    task automatic test_reset_mid();
        logic [39:0] ea;
        logic [39:0] ee;
        ea = pack(1'b1, 1'b1, 5'd24, 32'h4444, 1'b0);
        ee = pack(1'b1, 1'b1, 5'd31, 32'h0000_1008, 1'b1);
        drive(1'b1, 32'h0, 32'h0, 5'd24, 1'b1, 32'h4444);
        tick();
        drive(1'b1, 32'h0, 32'h0, 5'd25, 1'b1, 32'h5555);
        tick();
        checks++;
        if (obs() !== ea) begin
            failures++;
            $display("FAIL rstmid_pre got=%h exp=%h", obs(), ea);
        end
        bus.stall = 1'b1;
        reset_n   = 1'b0;
        #1;
        checks++;
        if (obs() !== 40'h0) begin
            failures++;
            $display("FAIL rstmid_async got=%h exp=%h", obs(), 40'h0);
        end
        @(negedge clk);
        reset_n   = 1'b1;
        bus.stall = 1'b0;
        drive(1'b1, 32'h0C00_0000, 32'h1000, 5'd1, 1'b0, 32'h0);
        tick();
        checks++;
        if (obs() !== 40'h0) begin
            failures++;
            $display("FAIL rstmid_early got=%h exp=%h", obs(), 40'h0);
        end
        bubble();
        tick();
        checks++;
        if (obs() !== ee) begin
            failures++;
            $display("FAIL rstmid_first got=%h exp=%h", obs(), ee);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_jal();
        test_link_forms();
        test_nonlink_and_wrap();
        test_stall();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/link_writeback_pipe.md
# link_writeback_pipe

Pipelined writeback-destination and link-data unit for the MIPS core. Classifies each instruction entering the decode/execute boundary as linking or non-linking, selects the destination register and writeback data (link address or ALU result), and carries the result through a parametrised number of pipeline stages to the register-file write port. Supports stall and flush control and suppresses writes to `$0`.

## Interface
- `DATA_WIDTH`, default 32: width of PC, ALU result and writeback data.
- `STAGES`, default 2: number of register stages between input and output (legal range 1..8).
- `LINK_REG`, default 31: destination register for JAL, BLTZAL and BGEZAL.
- `LINK_OFFSET`, default 8: byte offset added to `pc_in` to form the link address.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `valid_in`  in  1  input slot holds a real instruction.
- `stall`  in  1  hold every stage.
- `flush`  in  1  kill every in-flight entry.
- `instruction`  in  32  raw instruction word.
- `pc_in`  in  DATA_WIDTH  address of the instruction.
- `reg_write_addr_in`  in  5  decoder-selected destination (rt or rd).
- `reg_write_en_in`  in  1  decoder write enable.
- `alu_result`  in  DATA_WIDTH  non-link writeback data.
- `valid_out`  out  1  output slot valid.
- `reg_write_en_out`  out  1  register-file write enable.
- `reg_write_addr_out`  out  5  register-file write address.
- `reg_write_data_out`  out  DATA_WIDTH  register-file write data.
- `is_link_out`  out  1  the output entry is a linking instruction.

## Operation
- The classification is combinational on the input and is captured into stage 1.
- JAL is opcode `000011`. It forces link, with address `LINK_REG` and write enable 1.
- BLTZAL and BGEZAL are opcode `000001` with rt `10000` or `10001`. They force link, with address `LINK_REG` and write enable 1. Links occur regardless of branch outcome.
- JALR is opcode `000000` with funct `001001`. It links to `reg_write_addr_in` (the rd field), with write enable 1.
- Any other instruction is a non-link. It passes `reg_write_addr_in`, `reg_write_en_in` and `alu_result` through unchanged.
- Link data is `pc_in + LINK_OFFSET`, truncated to `DATA_WIDTH` bits (wraps modulo 2^DATA_WIDTH).
- Zero suppression: if the final address is 0, the write enable is forced to 0. `is_link_out` is still reported for a linking instruction.
- `valid_in` = 0 loads a bubble: valid=0, write enable=0, address=0, data=0, is_link=0.
- Each stage holds {valid, write enable, address, data, is_link}. On every non-stalled cycle, stage k+1 takes stage k.
- A bubble can never assert `reg_write_en_out`: `reg_write_en_out` = stage write enable AND stage valid.

## Timing
- Reset: while `reset_n` = 0, every stage clears immediately without waiting for a clock. All outputs are 0.
- After reset is released, the first capture happens on the next rising edge.
- Latency: an input accepted at edge N appears on the outputs after edge N+STAGES-1. The input is sampled at edge N into stage 1, and the outputs are driven from stage `STAGES`.
- Throughput is one instruction per cycle.
- `stall` = 1: no stage updates and the input is not captured. Outputs hold their values.
- `flush` = 1: on the edge, every stage is loaded with a bubble and the input is discarded.
- `flush` and `stall` both 1: flush wins.
- Reset asserted mid-stall or mid-flush: reset overrides both.
- With `STAGES` = 1, the outputs are driven directly from the single capture register.

## Test plan
- JAL: `instruction` = 0x0C000010, `pc_in` = 0x00400000, `valid_in` = 1 -> after STAGES edges: `reg_write_addr_out` = 31, `reg_write_data_out` = 0x00400008, `reg_write_en_out` = 1, `is_link_out` = 1.
- BGEZAL and JALR:
  - BGEZAL with rt = 17 -> address 31.
  - JALR with rd = 5 and `pc_in` = 0x100 -> address 5, data 0x108.
  - JALR with rd = 0 -> `reg_write_en_out` = 0, `is_link_out` = 1.
- Non-link: ADDU with `reg_write_addr_in` = 9 and `alu_result` = 0xDEADBEEF -> address 9, data 0xDEADBEEF, `is_link_out` = 0.
- Wrap: JAL at `pc_in` = 0xFFFFFFFC -> data 0x00000004.
- Stall/flush:
  - 3 back-to-back valid instructions, then `stall` held 2 cycles -> outputs frozen and no entry lost or duplicated.
  - `flush` and `stall` asserted together -> next cycle `valid_out` = 0 and `reg_write_en_out` = 0.
- Reset mid-stream: drop `reset_n` between edges with the pipe full -> all outputs 0 immediately. After release, the first new instruction emerges exactly STAGES edges later.
